// File: rtl/johnson_seq_ctrl_pkg.sv
// Shared definitions for the Johnson phase-generator run controller:
// controller state encoding and the legal-pattern check.
package johnson_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    // Widest register the legal-pattern check accepts.
    localparam int MAX_WIDTH = 32;

    // A legal Johnson pattern is 0..01..1 or 1..10..0. Both forms have at
    // most one place where adjacent bits differ. Only the low 'width' bits
    // of q are examined.
    function automatic logic johnson_legal(input logic [MAX_WIDTH-1:0] q,
                                           input int                   width);
        int n_edges;
        n_edges = 0;
        for (int i = 0; i < MAX_WIDTH - 1; i++) begin
            if ((i < width - 1) && (q[i] != q[i+1])) begin
                n_edges++;
            end
        end
        return (n_edges <= 1);
    endfunction

endpackage

// File: rtl/johnson_stepper.sv
// WIDTH-stage Johnson register with a matching phase index.
// clr has priority over en. clr returns the register to the all-zero phase 0.
module johnson_stepper #(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_phase;

    // Shift in the inverted MSB on every enabled step. Phase tracks the step modulo 2*WIDTH.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            r_phase <= '0;
        end else if (clr) begin
            r_q     <= '0;
            r_phase <= '0;
        end else if (en) begin
            r_q     <= {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
        end
    end

    assign q     = r_q;
    assign phase = r_phase;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run controller for a Johnson phase generator. It runs a programmed number of
// full revolutions and supports hold and abort. It also recovers from illegal patterns.
// Every output comes from a register.
module johnson_seq_ctrl
    import johnson_seq_ctrl_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int CNT_W = 8,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * WIDTH - 1);

    state_e           r_state, w_state_n;
    logic [CNT_W-1:0] r_rem,   w_rem_n;
    logic             r_busy,  w_busy_n;
    logic             r_done,  w_done_n;
    logic             r_wrap,  w_wrap_n;
    logic             r_err,   w_err_n;

    logic             w_step_en;
    logic             w_step_clr;
    logic [WIDTH-1:0] w_q;
    logic [PW-1:0]    w_phase;
    logic             w_legal;

    johnson_stepper #(.WIDTH(WIDTH)) u_stepper (
        .clk   (clk),
        .reset (reset),
        .en    (w_step_en),
        .clr   (w_step_clr),
        .q     (w_q),
        .phase (w_phase)
    );

    assign w_legal = johnson_legal(MAX_WIDTH'(w_q), WIDTH);

    // Control state, revolution counter and the registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_rem   <= w_rem_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_wrap  <= w_wrap_n;
            r_err   <= w_err_n;
        end
    end

    // Next state. Priority is abort, then illegal-pattern correction, then hold, then step.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_n  = r_state;
        w_rem_n    = r_rem;
        w_busy_n   = r_busy;
        w_done_n   = 1'b0;
        w_wrap_n   = 1'b0;
        w_err_n    = r_err;
        w_step_en  = 1'b0;
        w_step_clr = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cycles != '0) begin
                        w_state_n  = ST_RUN;
                        w_busy_n   = 1'b1;
                        w_rem_n    = cycles;
                        w_err_n    = 1'b0;
                        w_step_clr = 1'b1;
                    end else begin
                        w_done_n = 1'b1;
                    end
                end
            end

            ST_RUN, ST_PAUSED: begin
                if (abort) begin
                    w_state_n  = ST_IDLE;
                    w_busy_n   = 1'b0;
                    w_rem_n    = '0;
                    w_step_clr = 1'b1;
                end else if (!w_legal) begin
                    // Restart the revolution from phase 0. Completed revolutions still count.
                    w_step_clr = 1'b1;
                    w_err_n    = 1'b1;
                end else if (hold) begin
                    w_state_n = ST_PAUSED;
                end else begin
                    w_state_n = ST_RUN;
                    w_step_en = 1'b1;
                    if (w_phase == LAST_PHASE) begin
                        // The register steps back to all-zero on this edge, which completes a revolution.
                        w_wrap_n = 1'b1;
                        w_rem_n  = r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            w_done_n  = 1'b1;
                            w_busy_n  = 1'b0;
                            w_state_n = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_n  = ST_IDLE;
                w_busy_n   = 1'b0;
                w_rem_n    = '0;
                w_step_clr = 1'b1;
            end
        endcase
    end

    assign q     = w_q;
    assign phase = w_phase;
    assign busy  = r_busy;
    assign done  = r_done;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl. It runs a per-cycle vector table,
// then hand-written corner sequences, then random traffic checked against a
// revolution-level behavioural model.
module tb_johnson_seq_ctrl;

    localparam int W   = 4;
    localparam int CW  = 8;
    localparam int NPH = 2 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] cycles;
    logic          hold;
    logic          abort;
    logic [W-1:0]  q;
    logic [2:0]    phase;
    logic          busy, done, wrap, err;

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cycles (cycles),
        .hold   (hold),
        .abort  (abort),
        .q      (q),
        .phase  (phase),
        .busy   (busy),
        .done   (done),
        .wrap   (wrap),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: an active flag, a step index and the revolutions left.
    bit m_busy, m_done, m_wrap, m_err;
    int m_phase, m_rem;

    // Activity observed on the DUT outputs over one scenario.
    int n_busy, n_wrap, n_done;

    typedef struct {
        bit            st;
        logic [CW-1:0] cyc;
        bit            hl;
        bit            ab;
        logic [W-1:0]  eq;
        int            eph;
        bit            ebusy;
        bit            edone;
        bit            ewrap;
    } vec_t;

    vec_t tbl[14];

    function automatic int johnson_of(input int p);
        if (p <= W) return (1 << p) - 1;
        return ((1 << W) - 1) & ~((1 << (p - W)) - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_wrap = 0; m_err = 0; m_phase = 0; m_rem = 0;
    endtask

    task automatic model_edge(input bit s, input int c, input bit h, input bit a, input bit inj);
        m_done = 0;
        m_wrap = 0;
        if (!m_busy) begin
            if (s) begin
                if (c != 0) begin
                    m_busy = 1; m_phase = 0; m_rem = c; m_err = 0;
                end else begin
                    m_done = 1;
                end
            end
        end else if (a) begin
            m_busy = 0; m_phase = 0; m_rem = 0;
        end else if (inj) begin
            m_phase = 0; m_err = 1;
        end else if (!h) begin
            m_phase = (m_phase + 1) % NPH;
            if (m_phase == 0) begin
                m_wrap = 1;
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1; m_busy = 0;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".q"},     int'(q),     johnson_of(m_phase));
        check({tag, ".phase"}, int'(phase), m_phase);
        check({tag, ".busy"},  int'(busy),  int'(m_busy));
        check({tag, ".done"},  int'(done),  int'(m_done));
        check({tag, ".wrap"},  int'(wrap),  int'(m_wrap));
        check({tag, ".err"},   int'(err),   int'(m_err));
    endtask

    // Drive one cycle of inputs, let one edge pass, then compare against the model.
    task automatic apply(input string tag, input bit s, input int c, input bit h,
                         input bit a, input bit inj = 1'b0);
        start = s; cycles = CW'(c); hold = h; abort = a;
        @(posedge clk);
        model_edge(s, c, h, a, inj);
        #1;
        compare_model(tag);
        if (busy) n_busy++;
        if (wrap) n_wrap++;
        if (done) n_done++;
    endtask

    task automatic clear_tallies();
        n_busy = 0; n_wrap = 0; n_done = 0;
    endtask

    initial begin
        // Table: cycles=1 run held for three cycles at phase 3, then a cycles=0 request.
        tbl[0]  = '{1, 8'd1, 0, 0, 4'b0000, 0, 1, 0, 0};
        tbl[1]  = '{0, 8'd0, 0, 0, 4'b0001, 1, 1, 0, 0};
        tbl[2]  = '{0, 8'd0, 0, 0, 4'b0011, 2, 1, 0, 0};
        tbl[3]  = '{0, 8'd0, 0, 0, 4'b0111, 3, 1, 0, 0};
        tbl[4]  = '{0, 8'd0, 1, 0, 4'b0111, 3, 1, 0, 0};
        tbl[5]  = '{0, 8'd0, 1, 0, 4'b0111, 3, 1, 0, 0};
        tbl[6]  = '{0, 8'd0, 1, 0, 4'b0111, 3, 1, 0, 0};
        tbl[7]  = '{0, 8'd0, 0, 0, 4'b1111, 4, 1, 0, 0};
        tbl[8]  = '{0, 8'd0, 0, 0, 4'b1110, 5, 1, 0, 0};
        tbl[9]  = '{0, 8'd0, 0, 0, 4'b1100, 6, 1, 0, 0};
        tbl[10] = '{0, 8'd0, 0, 0, 4'b1000, 7, 1, 0, 0};
        tbl[11] = '{0, 8'd0, 0, 0, 4'b0000, 0, 0, 1, 1};
        tbl[12] = '{1, 8'd0, 0, 0, 4'b0000, 0, 0, 1, 0};
        tbl[13] = '{0, 8'd0, 0, 0, 4'b0000, 0, 0, 0, 0};

        reset = 1'b1; start = 1'b0; cycles = '0; hold = 1'b0; abort = 1'b0;
        model_reset();
        #12;
        compare_model("reset");
        reset = 1'b0;

        // Vector table.
        clear_tallies();
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st; cycles = tbl[i].cyc; hold = tbl[i].hl; abort = tbl[i].ab;
            @(posedge clk);
            model_edge(tbl[i].st, int'(tbl[i].cyc), tbl[i].hl, tbl[i].ab, 1'b0);
            #1;
            check($sformatf("tbl%0d.q", i),     int'(q),     int'(tbl[i].eq));
            check($sformatf("tbl%0d.phase", i), int'(phase), tbl[i].eph);
            check($sformatf("tbl%0d.busy", i),  int'(busy),  int'(tbl[i].ebusy));
            check($sformatf("tbl%0d.done", i),  int'(done),  int'(tbl[i].edone));
            check($sformatf("tbl%0d.wrap", i),  int'(wrap),  int'(tbl[i].ewrap));
            if (busy) n_busy++;
        end
        check("hold.busy_cycles", n_busy, 11);

        // cycles=2: 16 busy cycles, two wraps, one done.
        clear_tallies();
        apply("run2", 1, 2, 0, 0);
        for (int i = 0; i < 17; i++) apply("run2", 0, 0, 0, 0);
        check("run2.busy_cycles", n_busy, 16);
        check("run2.wraps", n_wrap, 2);
        check("run2.dones", n_done, 1);

        // cycles=3 aborted at phase 5 of revolution 2, then a clean cycles=1 run.
        clear_tallies();
        apply("abort", 1, 3, 0, 0);
        for (int i = 0; i < 13; i++) apply("abort", 0, 0, 0, 0);
        check("abort.phase_before", int'(phase), 5);
        apply("abort", 0, 0, 0, 1);
        apply("abort", 0, 0, 0, 0);
        check("abort.wraps", n_wrap, 1);
        check("abort.dones", n_done, 0);
        clear_tallies();
        apply("after_abort", 1, 1, 0, 0);
        for (int i = 0; i < 9; i++) apply("after_abort", 0, 0, 0, 0);
        check("after_abort.dones", n_done, 1);

        // Asynchronous reset between edges, mid-run.
        apply("rst", 1, 2, 0, 0);
        for (int i = 0; i < 5; i++) apply("rst", 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_model("async_rst");
        @(negedge clk);
        reset = 1'b0;
        clear_tallies();
        apply("after_rst", 1, 1, 0, 0);
        for (int i = 0; i < 9; i++) apply("after_rst", 0, 0, 0, 0);
        check("after_rst.busy_cycles", n_busy, 8);

        // Illegal pattern injected mid-run. Recover to phase 0 and set the sticky err flag.
        clear_tallies();
        apply("illegal", 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) apply("illegal", 0, 0, 0, 0);
        force dut.u_stepper.r_q = 4'b0101;
        #1;
        release dut.u_stepper.r_q;
        apply("illegal.fix", 0, 0, 0, 0, 1'b1);
        check("illegal.err_set", int'(err), 1);
        for (int i = 0; i < 17; i++) apply("illegal.run", 0, 0, 0, 0);
        check("illegal.dones", n_done, 1);
        check("illegal.err_sticky", int'(err), 1);
        apply("illegal.restart", 1, 1, 0, 0);
        check("illegal.err_cleared", int'(err), 0);
        for (int i = 0; i < 9; i++) apply("illegal.tail", 0, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply("rand",
                  ($urandom % 4) == 0,
                  int'($urandom % 4),
                  ($urandom % 4) == 0,
                  ($urandom % 20) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
